fetch_unit: RTL and testbench

Instruction fetch front end placed between the PC/next-PC logic and the core's decode stage. It owns the architectural fetch PC and issues sequential requests to a synchronous instruction memory with one-cycle read latency. Returned words are buffered with their PC in a small FIFO and delivered to decode over a valid/ready handshake. Redirects from branches and jumps flush all in-flight and buffered work.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch front end.
//   WORD             : datapath / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   pc_next()        : sequential fetch address, wraps modulo 2^WORD
package fetch_unit_pkg;

    localparam int WORD = 32;
    localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [WORD-1:0] pc_next(input logic [WORD-1:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {instr, pc} pairs between instruction memory and decode.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail (caller guarantees space)
//   push_data  : {instr, pc}
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   count      : number of valid entries
//   head       : {instr, pc} of the head, or the last presented head when empty
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [2*WORD-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output logic [2*WORD-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [2*WORD-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [2*WORD-1:0] last_head;
    logic              pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop && (count != '0);

    // An empty buffer keeps presenting whatever was last at the head, so the
    // decode-side outputs hold their value instead of exposing stale slots.
    assign head = (count != '0) ? mem[rd_ptr] : last_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            last_head <= head;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)   wr_ptr <= ptr_inc(wr_ptr);
                if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues sequential requests
// to a one-cycle-latency instruction memory, buffers responses with their PC
// and hands them to decode over valid/ready. Redirects flush everything.
//   clk, rst                    : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc : taken branch / jump and its target
//   halt                        : stop issuing new requests
//   imem_req, imem_addr         : memory read request and address
//   imem_rdata                  : memory data, valid the cycle after imem_req
//   instr_valid, instr_ready    : decode handshake
//   instr, instr_pc             : head instruction and its PC
//   pc                          : next fetch address
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [WORD-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic [WORD-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [WORD-1:0] instr,
    output logic [WORD-1:0] instr_pc,
    output logic [WORD-1:0] pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic            inflight;
    logic            kill;
    logic [WORD-1:0] inflight_pc;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    logic            resp_push;
    logic            pop;
    logic [2*WORD-1:0] head;

    // Buffered entries plus the response already on its way must leave room,
    // so a landing response never finds the buffer full.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = !rst && !halt && !redirect_valid && (occ < (CW+1)'(DEPTH));
    assign imem_addr = pc;

    assign resp_push   = inflight && !kill;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = head[2*WORD-1:WORD];
    assign instr_pc    = head[WORD-1:0];

    // ---- request stage -> response stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            kill     <= redirect_valid ? inflight : 1'b0;
            inflight <= imem_req;
            if (redirect_valid) pc <= redirect_pc;
            else if (imem_req)  pc <= pc_next(pc);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) inflight_pc <= pc;
    end

    // ---- response stage -> decode buffer ----
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_push),
        .push_data ({imem_rdata, inflight_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #2;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        tick();
    endtask

    task automatic test_sequential();
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #2;
            if (c < 3) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(c * 4)) begin
                    errors++; $display("FAIL seq_req c%0d got %b/%h exp 1/%h", c, imem_req, imem_addr, c * 4);
                end
            end
            checks++;
            if (instr_valid !== (c >= 2)) begin
                errors++; $display("FAIL seq_valid c%0d got %b exp %b", c, instr_valid, c >= 2);
            end
            if (c >= 2) begin
                checks++;
                if (instr_pc !== 32'((c - 2) * 4) || instr !== mem_word(32'((c - 2) * 4))) begin
                    errors++; $display("FAIL seq_pc c%0d got %h/%h exp %h", c, instr_pc, instr, (c - 2) * 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        instr_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (c >= 3) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full c%0d got %b exp 0", c, imem_req); end
            end
            tick();
        end
        #2;
        checks++; if (pc !== 32'd12) begin errors++; $display("FAIL bp_pc got %h exp 0000000c", pc); end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) #2;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instr !== mem_word(32'(k * 4))) begin
                errors++; $display("FAIL bp_drain k%0d got %b/%h exp 1/%h", k, instr_valid, instr_pc, k * 4);
            end
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        instr_ready = 1'b0;
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noissue got %b exp 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        #2;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_req got %b/%h exp 1/00000100", imem_req, imem_addr); end
        tick(); #2;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_kill got %b exp 0", instr_valid); end
        tick(); #2;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
            errors++; $display("FAIL redir_first got %b/%h exp 1/00000100", instr_valid, instr_pc);
        end
        tick(); #2;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
            errors++; $display("FAIL redir_second got %b/%h exp 1/00000104", instr_valid, instr_pc);
        end
        tick();
    endtask

    task automatic test_redirect_pop();
        do_reset();
        instr_ready = 1'b1;
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000;
        #2;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL rpop_pre got %b/%h exp 1/0", instr_valid, instr_pc); end
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rpop_empty c%0d got %b exp 0", c, instr_valid); end
            tick();
        end
        #2;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000) begin errors++; $display("FAIL rpop_target got %b/%h exp 1/00002000", instr_valid, instr_pc); end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        instr_ready = 1'b1;
        tick(); tick(); tick();
        halt = 1'b1;
        for (int c = 3; c < 8; c++) begin
            #2;
            checks++; if (imem_req !== 1'b0 || pc !== 32'd12) begin errors++; $display("FAIL halt_req c%0d got %b/%h exp 0/0000000c", c, imem_req, pc); end
            checks++;
            if (c < 5) begin
                if (instr_valid !== 1'b1 || instr_pc !== 32'((c - 2) * 4)) begin errors++; $display("FAIL halt_drain c%0d got %b/%h exp 1/%h", c, instr_valid, instr_pc, (c - 2) * 4); end
            end else begin
                if (instr_valid !== 1'b0 || instr_pc !== 32'd8) begin errors++; $display("FAIL halt_empty c%0d got %b/%h exp 0/00000008", c, instr_valid, instr_pc); end
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        #2;
        checks++; if (pc !== 32'h400 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_redir got %h/%b exp 00000400/0", pc, imem_req); end
        tick();
        halt = 1'b0;
        #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL halt_resume got %b/%h exp 1/00000400", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #2;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req0 got %b/%h exp 1/fffffffc", imem_req, imem_addr); end
        tick(); #2;
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req1 got %b/%h exp 1/00000000", imem_req, imem_addr); end
        tick(); #2;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out0 got %b/%h exp 1/fffffffc", instr_valid, instr_pc); end
        tick(); #2;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_out1 got %b/%h exp 1/00000000", instr_valid, instr_pc); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL midrst got %b/%b/%h exp 0/0/00000000", instr_valid, imem_req, pc);
        end
        tick();
        rst = 1'b0;
        #2;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_restart got %b/%h exp 1/00000000", imem_req, imem_addr); end
        tick(); tick(); #2;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL midrst_first got %b/%h exp 1/00000000", instr_valid, instr_pc); end
        tick();
    endtask

    // Fetched addresses form runs of consecutive words that restart at every
    // redirect target; decode must see exactly those words, in order.
    task automatic test_random();
        logic [31:0] exp_fetch;
        logic [31:0] exp_deliver;
        int delivered;
        bit seen;
        do_reset();
        exp_fetch = 32'h0;
        exp_deliver = 32'h0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc = 32'($urandom_range(0, 4095)) << 2;
            if ($urandom % 16 == 0) halt = !halt;
            #2;
            checks++; if (pc !== exp_fetch) begin errors++; $display("FAIL rnd_pc c%0d got %h exp %h", c, pc, exp_fetch); end
            if (halt || redirect_valid) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_noreq c%0d got %b exp 0", c, imem_req); end
            end
            if (imem_req) begin
                checks++; if (imem_addr !== exp_fetch) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, imem_addr, exp_fetch); end
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                checks++;
                if (instr_pc !== exp_deliver || instr !== mem_word(exp_deliver)) begin
                    errors++; $display("FAIL rnd_deliver c%0d got %h/%h exp %h/%h", c, instr_pc, instr, exp_deliver, mem_word(exp_deliver));
                end
                exp_deliver = exp_deliver + 32'd4;
                delivered++;
            end
            if (redirect_valid) begin
                exp_fetch = redirect_pc;
                exp_deliver = redirect_pc;
            end else if (imem_req) begin
                exp_fetch = exp_fetch + 32'd4;
            end
            tick();
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
        instr_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #2;
            if (instr_valid) seen = 1'b1;
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL rnd_liveness got valid 0 exp 1 within 10 cycles"); end
        checks++; if (delivered < 500) begin errors++; $display("FAIL rnd_delivered got %0d exp >= 500", delivered); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pop();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
